// File: rtl/match_controller.sv
// Round/match sequencer for N-player tank game: countdown, play, round-over, match-over phases.
// Optional PLAY time limit is enabled by defining MATCH_TIMEOUT_EN.
module match_controller #(
    parameter int unsigned NUM_PLAYERS      = 2,
    parameter int unsigned SCORE_W          = 4,
    parameter int unsigned WIN_SCORE        = 5,
    parameter int unsigned COUNTDOWN_FRAMES = 180,
    parameter int unsigned ROUNDOVER_FRAMES = 120,
    parameter int unsigned ROUND_FRAMES     = 3600
) (
    input  logic                            Clk,
    input  logic                            Reset_n,
    input  logic                            frame_tick,
    input  logic                            start,
    input  logic [NUM_PLAYERS-1:0]          hit,
    output logic [2:0]                      state,
    output logic                            play_en,
    output logic                            round_rst,
    output logic [NUM_PLAYERS-1:0]          alive,
    output logic [NUM_PLAYERS*SCORE_W-1:0]  scores,
    output logic [15:0]                     frames_left,
    output logic [7:0]                      round_num,
    output logic                            winner_valid,
    output logic [$clog2(NUM_PLAYERS)-1:0]  winner_id
);

    localparam int unsigned IdW = $clog2(NUM_PLAYERS);
    localparam logic [SCORE_W-1:0] ScoreMax  = '1;
    localparam logic [SCORE_W-1:0] WinScore  = SCORE_W'(WIN_SCORE);
    localparam logic [15:0]        CdLoad    = 16'(COUNTDOWN_FRAMES);
    localparam logic [15:0]        RoLoad    = 16'(ROUNDOVER_FRAMES);
`ifdef MATCH_TIMEOUT_EN
    localparam logic [15:0]        PlayLoad  = 16'(ROUND_FRAMES);
`else
    localparam logic [15:0]        PlayLoad  = 16'd0;
`endif

    // Elaboration-time parameter sanity checks.
    if (NUM_PLAYERS < 2 || NUM_PLAYERS > 8) begin : gen_bad_players
        $error("NUM_PLAYERS must be 2..8");
    end
    if (WIN_SCORE < 1 || WIN_SCORE > (2 ** SCORE_W) - 1) begin : gen_bad_win
        $error("WIN_SCORE out of range for SCORE_W");
    end
    if (COUNTDOWN_FRAMES < 1 || COUNTDOWN_FRAMES > 65535 ||
        ROUNDOVER_FRAMES < 1 || ROUNDOVER_FRAMES > 65535 ||
        ROUND_FRAMES < 1 || ROUND_FRAMES > 65535) begin : gen_bad_frames
        $error("frame counts must be 1..65535");
    end

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StCountdown = 3'd1,
        StPlay      = 3'd2,
        StRoundOver = 3'd3,
        StMatchOver = 3'd4
    } state_e;

    state_e                         state_q, state_d;
    logic [15:0]                    frames_q, frames_d;
    logic [NUM_PLAYERS-1:0]         alive_q, alive_d;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores_q, scores_d;
    logic [7:0]                     round_q, round_d;
    logic                           round_rst_q, round_rst_d;
    logic [IdW-1:0]                 winner_q, winner_d;

    logic [NUM_PLAYERS-1:0] next_alive;
    logic [3:0]             live_cnt;
    logic                   win_any;
    logic [IdW-1:0]         win_idx;

    always_comb begin
        next_alive = alive_q & ~hit;
        live_cnt   = 4'd0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            live_cnt = live_cnt + 4'(next_alive[i]);
        end
        win_any = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (scores_q[i*SCORE_W +: SCORE_W] >= WinScore) begin
                win_any = 1'b1;
                win_idx = IdW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        frames_d    = frames_q;
        alive_d     = alive_q;
        scores_d    = scores_q;
        round_d     = round_q;
        round_rst_d = 1'b0;
        winner_d    = winner_q;
        case (state_q)
            StIdle, StMatchOver: begin
                if (start) begin
                    state_d     = StCountdown;
                    frames_d    = CdLoad;
                    alive_d     = '1;
                    scores_d    = '0;
                    round_d     = 8'd1;
                    round_rst_d = 1'b1;
                end
            end
            StCountdown: begin
                if (frame_tick) begin
                    if (frames_q <= 16'd1) begin
                        state_d  = StPlay;
                        frames_d = PlayLoad;
                    end else begin
                        frames_d = frames_q - 16'd1;
                    end
                end
            end
            StPlay: begin
                alive_d = next_alive;
                if (live_cnt <= 4'd1) begin
                    // A kill outranks a same-cycle timer expiry; zero survivors is a draw.
                    state_d  = StRoundOver;
                    frames_d = RoLoad;
                    if (live_cnt == 4'd1) begin
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            if (next_alive[i] && scores_q[i*SCORE_W +: SCORE_W] != ScoreMax) begin
                                scores_d[i*SCORE_W +: SCORE_W] =
                                    scores_q[i*SCORE_W +: SCORE_W] + 1'b1;
                            end
                        end
                    end
                end
`ifdef MATCH_TIMEOUT_EN
                else if (frame_tick) begin
                    if (frames_q <= 16'd1) begin
                        state_d  = StRoundOver;
                        frames_d = RoLoad;
                    end else begin
                        frames_d = frames_q - 16'd1;
                    end
                end
`endif
            end
            StRoundOver: begin
                if (frame_tick) begin
                    if (frames_q <= 16'd1) begin
                        if (win_any) begin
                            state_d  = StMatchOver;
                            frames_d = 16'd0;
                            winner_d = win_idx;
                        end else begin
                            state_d     = StCountdown;
                            frames_d    = CdLoad;
                            alive_d     = '1;
                            round_d     = round_q + 8'd1;
                            round_rst_d = 1'b1;
                        end
                    end else begin
                        frames_d = frames_q - 16'd1;
                    end
                end
            end
            default: begin
                state_d  = StIdle;
                frames_d = 16'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= StIdle;
            frames_q    <= 16'd0;
            alive_q     <= '1;
            scores_q    <= '0;
            round_q     <= 8'd0;
            round_rst_q <= 1'b0;
            winner_q    <= '0;
        end else begin
            state_q     <= state_d;
            frames_q    <= frames_d;
            alive_q     <= alive_d;
            scores_q    <= scores_d;
            round_q     <= round_d;
            round_rst_q <= round_rst_d;
            winner_q    <= winner_d;
        end
    end

    assign state        = state_q;
    assign play_en      = (state_q == StPlay);
    assign round_rst    = round_rst_q;
    assign alive        = alive_q;
    assign scores       = scores_q;
    assign frames_left  = frames_q;
    assign round_num    = round_q;
    assign winner_valid = (state_q == StMatchOver);
    assign winner_id    = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed self-checking bench for match_controller: a default 2-player instance and a
// 4-player instance with short phases.
module tb_match_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 2-player instance, default parameters
    logic        ft_a, start_a;
    logic [1:0]  hit_a;
    logic [2:0]  state_a;
    logic        play_en_a, round_rst_a, winner_valid_a;
    logic [1:0]  alive_a;
    logic [7:0]  scores_a;
    logic [15:0] frames_a;
    logic [7:0]  round_a;
    logic [0:0]  winner_id_a;

    // 4-player instance, short phases
    logic        ft_b, start_b;
    logic [3:0]  hit_b;
    logic [2:0]  state_b;
    logic        play_en_b, round_rst_b, winner_valid_b;
    logic [3:0]  alive_b;
    logic [15:0] scores_b;
    logic [15:0] frames_b;
    logic [7:0]  round_b;
    logic [1:0]  winner_id_b;

    match_controller u_dut_a (
        .Clk          (clk),
        .Reset_n      (rst_n),
        .frame_tick   (ft_a),
        .start        (start_a),
        .hit          (hit_a),
        .state        (state_a),
        .play_en      (play_en_a),
        .round_rst    (round_rst_a),
        .alive        (alive_a),
        .scores       (scores_a),
        .frames_left  (frames_a),
        .round_num    (round_a),
        .winner_valid (winner_valid_a),
        .winner_id    (winner_id_a)
    );

    match_controller #(
        .NUM_PLAYERS      (4),
        .SCORE_W          (4),
        .WIN_SCORE        (5),
        .COUNTDOWN_FRAMES (3),
        .ROUNDOVER_FRAMES (2),
        .ROUND_FRAMES     (10)
    ) u_dut_b (
        .Clk          (clk),
        .Reset_n      (rst_n),
        .frame_tick   (ft_b),
        .start        (start_b),
        .hit          (hit_b),
        .state        (state_b),
        .play_en      (play_en_b),
        .round_rst    (round_rst_b),
        .alive        (alive_b),
        .scores       (scores_b),
        .frames_left  (frames_b),
        .round_num    (round_b),
        .winner_valid (winner_valid_b),
        .winner_id    (winner_id_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks_a(input int n);
        ft_a = 1'b1;
        repeat (n) step();
        ft_a = 1'b0;
    endtask

    task automatic ticks_b(input int n);
        ft_b = 1'b1;
        repeat (n) step();
        ft_b = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ft_a = 1'b0; start_a = 1'b0; hit_a = '0;
        ft_b = 1'b0; start_b = 1'b0; hit_b = '0;
        #12;
        check("rst_state", state_a, 3'd0);
        check("rst_alive", alive_a, 2'b11);
        check("rst_scores", scores_a, 8'h00);
        check("rst_round", round_a, 8'd0);
        check("rst_frames", frames_a, 16'd0);
        check("rst_play_en", play_en_a, 1'b0);
        rst_n = 1'b1;
        step();

        // Start with a coincident tick: the tick must not touch the freshly loaded counter.
        start_a = 1'b1; ft_a = 1'b1;
        step();
        start_a = 1'b0; ft_a = 1'b0;
        check("start_state", state_a, 3'd1);
        check("start_round_rst", round_rst_a, 1'b1);
        check("start_frames", frames_a, 16'd180);
        check("start_round", round_a, 8'd1);
        hit_a = 2'b01;
        step();
        hit_a = 2'b00;
        check("round_rst_one_cycle", round_rst_a, 1'b0);
        check("cd_hit_ignored", alive_a, 2'b11);
        ticks_a(179);
        check("cd_179_state", state_a, 3'd1);
        check("cd_179_frames", frames_a, 16'd1);
        check("cd_179_play_en", play_en_a, 1'b0);
        ticks_a(1);
        check("cd_done_state", state_a, 3'd2);
        check("cd_done_play_en", play_en_a, 1'b1);
        check("cd_done_frames", frames_a, 16'd0);

        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("play_start_ignored", state_a, 3'd2);
        check("play_start_round", round_a, 8'd1);
`ifndef MATCH_TIMEOUT_EN
        ticks_a(3);
        check("play_no_timer", frames_a, 16'd0);
`endif

        hit_a = 2'b10;
        step();
        hit_a = 2'b00;
        check("kill_alive", alive_a, 2'b01);
        check("kill_scores", scores_a, 8'h01);
        check("kill_state", state_a, 3'd3);
        check("kill_frames", frames_a, 16'd120);
        ticks_a(119);
        check("ro_119_state", state_a, 3'd3);
        ticks_a(1);
        check("ro_done_state", state_a, 3'd1);
        check("ro_done_round", round_a, 8'd2);
        check("ro_done_round_rst", round_rst_a, 1'b1);
        check("ro_done_alive", alive_a, 2'b11);

        ticks_a(180);
        hit_a = 2'b11;
        step();
        hit_a = 2'b00;
        check("draw_state", state_a, 3'd3);
        check("draw_scores", scores_a, 8'h01);
        check("draw_alive", alive_a, 2'b00);
        ticks_a(120);
        check("draw_next_round", round_a, 8'd3);

        // Player 0 takes four more rounds: 2, 3, 4, then 5 ends the match.
        for (int r = 2; r <= 5; r++) begin
            ticks_a(180);
            hit_a = 2'b10;
            step();
            hit_a = 2'b00;
            check("win_round_score", scores_a, 32'(r));
            ticks_a(120);
            check("win_round_state", state_a, (r == 5) ? 32'd4 : 32'd1);
        end
        check("mo_winner_valid", winner_valid_a, 1'b1);
        check("mo_winner_id", winner_id_a, 1'b0);
        check("mo_frames", frames_a, 16'd0);
        check("mo_play_en", play_en_a, 1'b0);
        ticks_a(5);
        check("mo_scores_held", scores_a, 8'h05);

        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("restart_state", state_a, 3'd1);
        check("restart_scores", scores_a, 8'h00);
        check("restart_round", round_a, 8'd1);
        check("restart_winner_valid", winner_valid_a, 1'b0);

        // Reach PLAY with a nonzero score, then reset asynchronously mid-cycle.
        ticks_a(180);
        hit_a = 2'b01;
        step();
        hit_a = 2'b00;
        check("p1_kill_scores", scores_a, 8'h10);
        ticks_a(120);
        ticks_a(180);
        check("pre_reset_state", state_a, 3'd2);
        rst_n = 1'b0;
        #1;
        check("async_rst_state", state_a, 3'd0);
        check("async_rst_scores", scores_a, 8'h00);
        check("async_rst_alive", alive_a, 2'b11);
        check("async_rst_play_en", play_en_a, 1'b0);
        #3;
        rst_n = 1'b1;
        step();

        // 4-player instance
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        ticks_b(3);
        check("b_play_state", state_b, 3'd2);
        hit_b = 4'b0010; step();
        check("b_hit1_alive", alive_b, 4'b1101);
        hit_b = 4'b1000; step();
        check("b_hit3_alive", alive_b, 4'b0101);
        hit_b = 4'b0010; step();
        check("b_repeat_alive", alive_b, 4'b0101);
        check("b_repeat_state", state_b, 3'd2);
        hit_b = 4'b0100; step();
        hit_b = 4'b0000;
        check("b_hit2_alive", alive_b, 4'b0001);
        check("b_hit2_scores", scores_b, 16'h0001);
        check("b_hit2_state", state_b, 3'd3);
        ticks_b(2);
        check("b_next_state", state_b, 3'd1);
        check("b_next_round", round_b, 8'd2);
        ticks_b(3);
        check("b_play2_state", state_b, 3'd2);
`ifdef MATCH_TIMEOUT_EN
        check("b_timer_load", frames_b, 16'd10);
        ticks_b(9);
        check("b_timer_9_state", state_b, 3'd2);
        check("b_timer_9_frames", frames_b, 16'd1);
        ticks_b(1);
        check("b_timeout_state", state_b, 3'd3);
        check("b_timeout_scores", scores_b, 16'h0001);
        check("b_timeout_alive", alive_b, 4'b1111);
`else
        ticks_b(10);
        check("b_no_timeout_state", state_b, 3'd2);
        check("b_no_timeout_frames", frames_b, 16'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Parametrised round/match sequencer for the multiplayer tank game; successor to the fixed two-player win1/win2 handling.
- Supports N players. Tracks which players are alive and keeps per-player scores.
- Sequences countdown, play and round-over phases on frame ticks, and pulses a round reset to the map and tank blocks.
- Declares a match winner at a configurable score. Sits between the tank instances (hit pulses in) and the map, tank, colour mapper and HEX logic (state and scores out).

Parameters:
NUM_PLAYERS, 2, number of players (2..8)
SCORE_W, 4, bits per player score
WIN_SCORE, 5, points needed to win the match (1..2^SCORE_W-1)
COUNTDOWN_FRAMES, 180, frames in COUNTDOWN (3 s at 60 Hz)
ROUNDOVER_FRAMES, 120, frames in ROUND_OVER
ROUND_FRAMES, 3600, PLAY time limit (used only with MATCH_TIMEOUT_EN)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-Clk pulse per video frame
start  in  1  one-Clk pulse; begins a match
hit  in  NUM_PLAYERS  bit i pulses when player i is destroyed
state  out  3  0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 ROUND_OVER, 4 MATCH_OVER
play_en  out  1  high only in PLAY; gates tank movement and firing
round_rst  out  1  one-Clk pulse on every entry to COUNTDOWN
alive  out  NUM_PLAYERS  alive mask for the current round
scores  out  NUM_PLAYERS*SCORE_W  player i score at [i*SCORE_W +: SCORE_W]
frames_left  out  16  remaining frames of the current timed phase; 0 otherwise
round_num  out  8  rounds started in this match
winner_valid  out  1  high in MATCH_OVER
winner_id  out  $clog2(NUM_PLAYERS)  match winner, valid when winner_valid

Behaviour:
- Reset (asynchronous, Reset_n=0) forces:
  - state=IDLE
  - all outputs 0, except alive = all ones
  - internal counters 0
- All transitions are registered; outputs are driven from registers.
- IDLE:
  - on start -> COUNTDOWN
  - scores cleared, round_num=1, round_rst pulses, alive = all ones, frames_left=COUNTDOWN_FRAMES
- COUNTDOWN:
  - each frame_tick decrements frames_left
  - the tick that reaches 0 -> PLAY (frames_left stays 0)
  - hit is ignored
- PLAY:
  - a hit bit clears the matching alive bit; a hit on an already-dead player is ignored
  - after applying hits in a cycle, evaluate next_alive:
    - popcount=1: survivor score +1, saturating at 2^SCORE_W-1; -> ROUND_OVER
    - popcount=0 (simultaneous final hits): draw, no score change; -> ROUND_OVER
  - the score update and the state change occur in the same cycle
  - start is ignored
- ROUND_OVER:
  - loads frames_left=ROUNDOVER_FRAMES on entry and decrements on frame_tick
  - at 0: if any score >= WIN_SCORE -> MATCH_OVER
  - otherwise -> COUNTDOWN: round_num +1 (wraps 255->0), alive = all ones, round_rst pulses
- MATCH_OVER:
  - winner_valid=1; winner_id = the player whose score >= WIN_SCORE (only one can qualify)
  - scores are held
  - on start -> same actions as the start from IDLE
- frame_tick and a transition in the same cycle: the transition wins; the tick is not applied to the newly loaded counter.
- A start pulse outside IDLE/MATCH_OVER has no effect.
- An undefined state encoding recovers to IDLE.

Optional Feature:
- Macro: MATCH_TIMEOUT_EN.
- When defined:
  - on entry to PLAY, frames_left loads ROUND_FRAMES and decrements on frame_tick
  - reaching 0 with popcount(alive)>1 is a draw -> ROUND_OVER, no score change
  - a kill in the same cycle as expiry takes priority over the timeout
- When undefined: no round timer; frames_left=0 in PLAY; ROUND_FRAMES is unused.

Test Plan:
- Reset_n low mid-PLAY -> same cycle: state=0, scores=0, alive=2'b11, play_en=0.
- start, then 180 frame_ticks -> round_rst high exactly 1 cycle; state=COUNTDOWN; play_en rises after the 180th tick.
- PLAY, hit=2'b10 -> alive=2'b01, scores[3:0]=1, state=ROUND_OVER; after 120 ticks -> COUNTDOWN, round_num=2.
- PLAY, hit=2'b11 in one cycle -> draw, scores unchanged, state=ROUND_OVER.
- Player 0 wins 5 rounds -> MATCH_OVER, winner_valid=1, winner_id=0; a later start clears scores and sets round_num=1.
- NUM_PLAYERS=4: hits on players 1, 3, 1 (repeat), 2 -> repeat ignored; player 0 scores; with MATCH_TIMEOUT_EN and ROUND_FRAMES=10, no hits -> draw after 10 ticks.
